rv_decode_stage: RTL

- Registered RISC-V instruction-decode pipeline stage, generalised over XLEN.
- Sits between the instruction fetch unit (IFU) and the execute unit (EXU).
- Accepts {pc, inst} over a valid/ready handshake and produces the decoded fields plus one format-selected, sign-extended XLEN-bit immediate.
- A 1-entry skid buffer gives full throughput under back-pressure; a synchronous flush squashes in-flight instructions on redirect.

---
 rtl/rv_decode_stage_if.sv | 42 ++++
 rtl/rv_decode_stage.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/rv_decode_stage_if.sv
// ---------------------------------------------------------------------------
// rv_decode_stage_if
// Bus bundle between the fetch side, the decode stage and the execute side.
//   in_*  : {pc, inst} stream from the IFU, valid/ready handshake
//   out_* : decoded bundle stream towards the EXU, valid/ready handshake
// Modports:
//   slave  : the decode stage's view (consumes in_*, produces out_*)
//   master : the surrounding environment's view (IFU + EXU together)
// ---------------------------------------------------------------------------
interface rv_decode_stage_if #(
    parameter int XLEN = 32
);
    logic            in_valid;
    logic            in_ready;
    logic [XLEN-1:0] in_pc;
    logic [31:0]     in_inst;

    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] out_pc;
    logic [6:0]      out_opcode;
    logic [2:0]      out_func3;
    logic [6:0]      out_func7;
    logic [4:0]      out_rs1;
    logic [4:0]      out_rs2;
    logic [4:0]      out_rd;
    logic [XLEN-1:0] out_imm;
    logic [2:0]      out_fmt;
    logic            out_illegal;

    modport slave (
        input  in_valid, in_pc, in_inst, out_ready,
        output in_ready, out_valid, out_pc, out_opcode, out_func3, out_func7,
               out_rs1, out_rs2, out_rd, out_imm, out_fmt, out_illegal
    );

    modport master (
        output in_valid, in_pc, in_inst, out_ready,
        input  in_ready, out_valid, out_pc, out_opcode, out_func3, out_func7,
               out_rs1, out_rs2, out_rd, out_imm, out_fmt, out_illegal
    );
endinterface

// File: rtl/rv_decode_stage.sv
// ---------------------------------------------------------------------------
// rv_decode_stage
// Registered RISC-V instruction decode stage between IFU and EXU.
// Decodes {pc, inst} into register fields, instruction format and a
// sign-extended XLEN-bit immediate with one cycle of latency. An optional
// 1-entry skid register keeps full throughput under back-pressure.
// Ports:
//   clk   : clock
//   rst   : synchronous active-high reset (dominates flush)
//   flush : synchronous squash of every held instruction, including one
//           accepted in the same cycle
//   bus   : rv_decode_stage_if.slave, input stream + decoded output stream
// Parameters:
//   XLEN    : 32 or 64, width of pc and immediate
//   SKID_EN : 1 = skid register (in_ready = !skid_valid, registered)
//             0 = no skid (in_ready = !out_valid | out_ready)
// ---------------------------------------------------------------------------
module rv_decode_stage #(
    parameter int XLEN    = 32,
    parameter bit SKID_EN = 1'b1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               flush,
    rv_decode_stage_if.slave   bus
);
    localparam logic [2:0] FMT_R = 3'd0;
    localparam logic [2:0] FMT_I = 3'd1;
    localparam logic [2:0] FMT_S = 3'd2;
    localparam logic [2:0] FMT_B = 3'd3;
    localparam logic [2:0] FMT_U = 3'd4;
    localparam logic [2:0] FMT_J = 3'd5;

    // Register fields are sliced from the stored instruction word, so only
    // the parts that need real decode logic are kept separately.
    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [31:0]     inst;
        logic [XLEN-1:0] imm;
        logic [2:0]      fmt;
        logic            illegal;
    } bundle_t;

    bundle_t dec_next;
    bundle_t out_reg;
    bundle_t skid_reg;
    logic    out_valid_reg;
    logic    skid_valid_reg;

    logic        accept;
    logic        out_fire;
    logic [31:0] inst;
    logic [6:0]  opcode;
    logic signed [31:0] imm32;

    assign inst     = bus.in_inst;
    assign opcode   = inst[6:0];
    assign accept   = bus.in_valid & bus.in_ready;
    assign out_fire = out_valid_reg & bus.out_ready;

    // Combinational decode of the incoming word. The immediate is built at
    // 32 bits and sign-extended once to XLEN; for U-type this extends from
    // bit 31, which is what RV64 requires.
    always_comb begin
        dec_next         = '0;
        dec_next.pc      = bus.in_pc;
        dec_next.inst    = inst;
        dec_next.fmt     = FMT_R;
        dec_next.illegal = 1'b0;
        imm32            = '0;

        case (opcode)
            7'b0010011, 7'b0000011, 7'b1100111, 7'b1110011: dec_next.fmt = FMT_I;
            7'b0100011: dec_next.fmt = FMT_S;
            7'b1100011: dec_next.fmt = FMT_B;
            7'b0110111, 7'b0010111: dec_next.fmt = FMT_U;
            7'b1101111: dec_next.fmt = FMT_J;
            7'b0110011: dec_next.fmt = FMT_R;
            // OP-IMM-32 / OP-32 exist only on RV64
            7'b0011011: begin
                if (XLEN == 64) dec_next.fmt = FMT_I;
                else            dec_next.illegal = 1'b1;
            end
            7'b0111011: begin
                if (XLEN != 64) dec_next.illegal = 1'b1;
            end
            default: dec_next.illegal = 1'b1;
        endcase

        if (inst[1:0] != 2'b11) dec_next.illegal = 1'b1;

        if (!dec_next.illegal) begin
            case (dec_next.fmt)
                FMT_I:   imm32 = 32'($signed(inst[31:20]));
                FMT_S:   imm32 = 32'($signed({inst[31:25], inst[11:7]}));
                FMT_B:   imm32 = 32'($signed({inst[31], inst[7], inst[30:25], inst[11:8], 1'b0}));
                FMT_U:   imm32 = $signed({inst[31:12], 12'b0});
                FMT_J:   imm32 = 32'($signed({inst[31], inst[19:12], inst[20], inst[30:21], 1'b0}));
                default: imm32 = '0;
            endcase
        end
        dec_next.imm = XLEN'(imm32);
    end

    generate
        if (SKID_EN) begin : g_skid_ready
            assign bus.in_ready = !skid_valid_reg;
        end else begin : g_pass_ready
            assign bus.in_ready = !out_valid_reg | bus.out_ready;
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            out_reg        <= '0;
            skid_reg       <= '0;
            out_valid_reg  <= 1'b0;
            skid_valid_reg <= 1'b0;
        end else if (flush) begin
            out_valid_reg  <= 1'b0;
            skid_valid_reg <= 1'b0;
        end else if (out_fire || !out_valid_reg) begin
            // Output register is free this cycle: the skid entry is older
            // than anything on the input, so it goes first. in_ready is low
            // while the skid is full, so no input can arrive alongside it.
            if (skid_valid_reg) begin
                out_reg        <= skid_reg;
                out_valid_reg  <= 1'b1;
                skid_valid_reg <= 1'b0;
            end else if (accept) begin
                out_reg       <= dec_next;
                out_valid_reg <= 1'b1;
            end else begin
                out_valid_reg <= 1'b0;
            end
        end else if (SKID_EN && accept) begin
            // Output stalled: park the new instruction in the skid.
            skid_reg       <= dec_next;
            skid_valid_reg <= 1'b1;
        end
    end

    assign bus.out_valid   = out_valid_reg;
    assign bus.out_pc      = out_reg.pc;
    assign bus.out_opcode  = out_reg.inst[6:0];
    assign bus.out_func3   = out_reg.inst[14:12];
    assign bus.out_func7   = out_reg.inst[31:25];
    assign bus.out_rs1     = out_reg.inst[19:15];
    assign bus.out_rs2     = out_reg.inst[24:20];
    assign bus.out_rd      = out_reg.inst[11:7];
    assign bus.out_imm     = out_reg.imm;
    assign bus.out_fmt     = out_reg.fmt;
    assign bus.out_illegal = out_reg.illegal;
endmodule
